// File: rtl/misr_ora_param.sv
// Parametrised MISR output response analyser: compacts a response bus into
// a signature over a fixed pattern count and compares it with a golden value.
module misr_ora_param #(
   parameter int               WIDTH        = 8,
   parameter int               IN_W         = 2,
   parameter logic [WIDTH-1:0] POLY         = 8'h1D,
   parameter logic [WIDTH-1:0] SEED         = '0,
   parameter int               NUM_PATTERNS = 16
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic                                  data_valid,
   input  logic [IN_W-1:0]                       datain,
   input  logic [WIDTH-1:0]                      golden,
   output logic [WIDTH-1:0]                      signature,
   output logic [$clog2(NUM_PATTERNS+1)-1:0]     pattern_count,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  pass
);

   localparam int CW = $clog2(NUM_PATTERNS+1);
   localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS);

   localparam logic [1:0] IDLE    = 2'b00;
   localparam logic [1:0] CAPTURE = 2'b01;
   localparam logic [1:0] DONE    = 2'b10;

   logic [1:0]       state;
   logic [WIDTH-1:0] next_sig;
   logic [CW-1:0]    count_inc;
   logic             fb;

   // Shift with tap feedback, then fold the response word into the low bits.
   always_comb begin
      fb       = signature[WIDTH-1];
      next_sig = {signature[WIDTH-2:0], 1'b0} ^ (POLY & {WIDTH{fb}});
      for (int i = 0; i < IN_W; i++)
         next_sig[i] = next_sig[i] ^ datain[i];
   end

   assign count_inc = pattern_count + 1'b1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         signature     <= '0;
         pattern_count <= '0;
         pass          <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state         <= CAPTURE;
                  signature     <= SEED;
                  pattern_count <= '0;
                  pass          <= 1'b0;
               end
            end
            CAPTURE: begin
               if (data_valid) begin
                  signature     <= next_sig;
                  pattern_count <= count_inc;
                  if (count_inc == LAST) begin
                     state <= DONE;
                     pass  <= (next_sig == golden);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == CAPTURE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_misr_ora_param.sv
// Directed bench for misr_ora_param: small 4-bit configs with hand-computed
// signatures plus the default 8-bit config against a reference model.
module tb_misr_ora_param;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       data_valid = 1'b0;
   logic [1:0] datain = '0;
   logic [3:0] g4 = '0;
   logic [7:0] g8 = '0;

   logic [3:0] a_sig, c_sig, d_sig;
   logic [2:0] a_cnt, c_cnt, d_cnt;
   logic       a_busy, a_done, a_pass;
   logic       c_busy, c_done, c_pass;
   logic       d_busy, d_done, d_pass;
   logic [7:0] e_sig;
   logic [4:0] e_cnt;
   logic       e_busy, e_done, e_pass;

   int n_chk = 0;
   int n_ok  = 0;

   logic [3:0] exp4 [4];
   logic [1:0] words [16];
   logic [7:0] m, mf;

   misr_ora_param #(.WIDTH(4), .IN_W(2), .POLY(4'h3), .SEED(4'h0),
                    .NUM_PATTERNS(4)) u_a (
      .clock(clock), .reset(reset), .start(start),
      .data_valid(data_valid), .datain(datain), .golden(g4),
      .signature(a_sig), .pattern_count(a_cnt),
      .busy(a_busy), .done(a_done), .pass(a_pass));

   misr_ora_param #(.WIDTH(4), .IN_W(2), .POLY(4'h3), .SEED(4'h0),
                    .NUM_PATTERNS(5)) u_c (
      .clock(clock), .reset(reset), .start(start),
      .data_valid(data_valid), .datain(datain), .golden(g4),
      .signature(c_sig), .pattern_count(c_cnt),
      .busy(c_busy), .done(c_done), .pass(c_pass));

   misr_ora_param #(.WIDTH(4), .IN_W(2), .POLY(4'h3), .SEED(4'h5),
                    .NUM_PATTERNS(5)) u_d (
      .clock(clock), .reset(reset), .start(start),
      .data_valid(data_valid), .datain(datain), .golden(g4),
      .signature(d_sig), .pattern_count(d_cnt),
      .busy(d_busy), .done(d_done), .pass(d_pass));

   misr_ora_param u_e (
      .clock(clock), .reset(reset), .start(start),
      .data_valid(data_valid), .datain(datain), .golden(g8),
      .signature(e_sig), .pattern_count(e_cnt),
      .busy(e_busy), .done(e_done), .pass(e_pass));

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      n_chk++;
      if (got === want) n_ok++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, want);
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   function automatic logic [7:0] m8(input logic [7:0] s,
                                     input logic [1:0] d);
      logic [7:0] r;
      r = {s[6:0], 1'b0};
      if (s[7]) r = r ^ 8'h1D;
      r[1:0] = r[1:0] ^ d;
      return r;
   endfunction

   initial begin
      exp4 = '{4'h1, 4'h3, 4'h7, 4'hF};

      step; step;
      reset = 1'b1;
      step;
      check("rst_sig", a_sig, 0);
      check("rst_cnt", a_cnt, 0);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      check("rst_e_sig", e_sig, 0);

      // Reset dropped mid-run must clear state without a clock edge.
      start = 1'b1; step; start = 1'b0;
      check("seed_sig", a_sig, 0);
      check("seed_busy", a_busy, 1);
      data_valid = 1'b1; datain = 2'b01;
      repeat (3) step;
      check("mid_sig", a_sig, 4'h7);
      check("mid_cnt", a_cnt, 3);
      #2 reset = 1'b0;
      #1;
      check("async_sig", a_sig, 0);
      check("async_cnt", a_cnt, 0);
      check("async_busy", a_busy, 0);
      check("async_done", a_done, 0);
      check("async_pass", a_pass, 0);
      data_valid = 1'b0;
      #1 reset = 1'b1;
      step;

      g4 = 4'hF;
      start = 1'b1; step; start = 1'b0;
      data_valid = 1'b1; datain = 2'b01;
      for (int i = 0; i < 4; i++) begin
         step;
         check("nofb_sig", a_sig, exp4[i]);
         check("nofb_cnt", a_cnt, i + 1);
         check("nofb_done", a_done, (i == 3) ? 1 : 0);
         check("c_notdone", c_done, 0);
      end
      check("nofb_pass", a_pass, 1);
      step;
      check("fb_sig", c_sig, 4'hC);
      check("fb_done", c_done, 1);
      check("fb_pass", c_pass, 0);
      check("held_sig", a_sig, 4'hF);
      check("held_cnt", a_cnt, 4);
      data_valid = 1'b0;
      step;

      start = 1'b1; step; start = 1'b0;
      data_valid = 1'b1;
      step; step;
      data_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) start = 1'b1;
         step;
         start = 1'b0;
         check("stall_sig", c_sig, 4'h3);
         check("stall_cnt", c_cnt, 2);
         check("stall_busy", c_busy, 1);
      end
      data_valid = 1'b1;
      step; step;
      check("stall_early", c_done, 0);
      step;
      check("stall_done", c_done, 1);
      check("stall_sig_f", c_sig, 4'hC);
      check("stall_cnt_f", c_cnt, 5);
      data_valid = 1'b0;

      start = 1'b1; step; start = 1'b0;
      check("reseed_sig", d_sig, 4'h5);
      check("reseed_cnt", d_cnt, 0);
      check("reseed_busy", d_busy, 1);
      check("reseed_done", d_done, 0);

      reset = 1'b0; step; reset = 1'b1; step;
      data_valid = 1'b1; datain = 2'b11;
      repeat (3) step;
      check("idle_sig", a_sig, 0);
      check("idle_busy", a_busy, 0);
      check("idle_e_sig", e_sig, 0);
      data_valid = 1'b0;

      for (int run = 0; run < 2; run++) begin
         mf = '0;
         for (int i = 0; i < 16; i++) begin
            words[i] = 2'($urandom_range(3, 0));
            mf = m8(mf, words[i]);
         end
         g8 = (run == 0) ? mf : (mf ^ 8'h01);
         start = 1'b1; step; start = 1'b0;
         check("e_seed", e_sig, 0);
         m = '0;
         for (int i = 0; i < 16; i++) begin
            datain = words[i];
            data_valid = 1'b1;
            step;
            m = m8(m, words[i]);
            check("e_sig", e_sig, m);
         end
         data_valid = 1'b0;
         check("e_cnt", e_cnt, 16);
         check("e_done", e_done, 1);
         check("e_pass", e_pass, (run == 0) ? 1 : 0);
         step;
      end

      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end

endmodule
